// File: rtl/vclk_pal_pkg.sv
// Shared types and default constants for the VDG PAL padding sequencer.
// Holds the FSM state encoding and the default PAL line geometry.
package vclk_pal_pkg;

  typedef enum logic [2:0] {
    WAIT_FS = 3'd0,
    COUNT   = 3'd1,
    TOP_PAD = 3'd2,
    PAD     = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int PAL_PAD_START = 192;
  localparam int PAL_PAD_LINES = 25;
  localparam int LINE_W        = 9;
  localparam int PAD_CNT_W     = 6;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an async active-low sync pin, plus a
// falling-edge pulse. Ports: Clk, Reset, async_in -> fall (1 Clk).
module sync_edge_det (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic fall
);

  logic s1, s2, s3;

  // Flops reset high (idle level) so reset release makes no edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;

endmodule

// File: rtl/vclk_pad_scheduler.sv
// VDG clock-inhibit sequencer: counts lines from HSync/FSync and opens
// the PAL padding window(s). Ports: Clk, Reset, nHSync, nFSync, Enable
// in; Line24, VClkPulse, PadActive, LineCount, Overrun out.
// Macro VCLK_TOP_PAD_EN adds a second (top border) window at TOP_START.
module vclk_pad_scheduler #(
  parameter int PAD_START = vclk_pal_pkg::PAL_PAD_START,
  parameter int PAD_LINES = vclk_pal_pkg::PAL_PAD_LINES,
  parameter int LINE_W    = vclk_pal_pkg::LINE_W,
  parameter int TOP_START = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              nHSync,
  input  logic              nFSync,
  input  logic              Enable,
  output logic              Line24,
  output logic              VClkPulse,
  output logic              PadActive,
  output logic [LINE_W-1:0] LineCount,
  output logic              Overrun
);

  import vclk_pal_pkg::*;

  logic hs_fall, fs_fall;

  sync_edge_det u_hs (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (nHSync),
    .fall     (hs_fall)
  );

  sync_edge_det u_fs (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (nFSync),
    .fall     (fs_fall)
  );

  state_t                 state_q, state_d;
  logic [PAD_CNT_W-1:0]   pad_q, pad_d;
  logic [LINE_W-1:0]      line_q;
  logic                   line24_q, line24_d;
  logic                   pulse_q, pulse_d;
  logic                   overrun_q;
  logic [LINE_W:0]        line_nx;
  logic                   in_pad;
  logic                   hit_bot;

  // One extra bit so a saturated count never aliases onto a start line.
  assign line_nx = {1'b0, line_q} + (LINE_W+1)'(1);
  assign hit_bot = hs_fall & Enable & (int'(line_nx) == PAD_START);

`ifdef VCLK_TOP_PAD_EN
  logic hit_top;
  assign hit_top = hs_fall & Enable & (int'(line_nx) == TOP_START);
  assign in_pad  = (state_q == PAD) | (state_q == TOP_PAD);
`else
  logic unused_top;
  assign unused_top = (TOP_START != 0);
  assign in_pad     = (state_q == PAD);
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= WAIT_FS;
      pad_q     <= '0;
      line_q    <= '0;
      line24_q  <= 1'b0;
      pulse_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pad_q    <= pad_d;
      line24_q <= line24_d;
      pulse_q  <= pulse_d;
      if (fs_fall)
        line_q <= '0;
      else if (hs_fall && line_q != '1)
        line_q <= line_q + 1'b1;
      if (fs_fall && in_pad)
        overrun_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    unique case (state_q)
      WAIT_FS: begin
        if (fs_fall) state_d = COUNT;
      end
      COUNT: begin
        if (fs_fall) begin
          state_d = COUNT;
        end else if (hit_bot) begin
          state_d = PAD;
          pad_d   = PAD_CNT_W'(PAD_LINES);
        end
`ifdef VCLK_TOP_PAD_EN
        else if (hit_top) begin
          state_d = TOP_PAD;
          pad_d   = PAD_CNT_W'(PAD_LINES);
        end
`endif
      end
`ifdef VCLK_TOP_PAD_EN
      TOP_PAD,
`endif
      PAD: begin
        if (fs_fall) begin
          state_d = COUNT;
          pad_d   = '0;
        end else if (hs_fall) begin
          pad_d = pad_q - 1'b1;
          // The hs_fall that empties the counter starts the first
          // unpadded line, so it closes the window without a pulse.
          if (pad_q == PAD_CNT_W'(1))
            state_d = (state_q == PAD) ? DONE : COUNT;
        end
      end
      DONE: begin
        if (fs_fall) state_d = COUNT;
      end
      default: state_d = WAIT_FS;
    endcase
  end

  always_comb begin
    line24_d = (state_d == PAD);
`ifdef VCLK_TOP_PAD_EN
    line24_d = line24_d | (state_d == TOP_PAD);
`endif
    pulse_d = line24_d & hs_fall & ~fs_fall;
  end

  assign Line24    = line24_q;
  assign PadActive = line24_q;
  assign VClkPulse = pulse_q;
  assign LineCount = line_q;
  assign Overrun   = overrun_q;

endmodule

// File: tb/tb_vclk_pad_scheduler.sv
// Randomised bench for vclk_pad_scheduler with a line-level model.
// Define VCLK_TOP_PAD_EN to exercise the top window at line 8.
module tb_vclk_pad_scheduler;

  localparam int PS   = 192;
  localparam int PL   = 25;
  localparam int LW   = 9;
  localparam int TS   = 8;
  localparam int LMAX = (1 << LW) - 1;
`ifdef VCLK_TOP_PAD_EN
  localparam int NWIN = 2 * PL;
`else
  localparam int NWIN = PL;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          nHSync = 1'b1;
  logic          nFSync = 1'b1;
  logic          Enable = 1'b0;
  logic          Line24, VClkPulse, PadActive, Overrun;
  logic [LW-1:0] LineCount;

  vclk_pad_scheduler #(
    .PAD_START (PS),
    .PAD_LINES (PL),
    .LINE_W    (LW),
    .TOP_START (TS)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .nHSync    (nHSync),
    .nFSync    (nFSync),
    .Enable    (Enable),
    .Line24    (Line24),
    .VClkPulse (VClkPulse),
    .PadActive (PadActive),
    .LineCount (LineCount),
    .Overrun   (Overrun)
  );

  always #5 Clk = ~Clk;

  int pulse_cnt = 0;
  always @(posedge Clk) if (VClkPulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Line-level model: a window is the run of PL lines starting at the
  // start line, opened only once per field and only if Enable is high.
  int line_m, win_start, prev_pulses, base;
  bit win_m, armed_bot, armed_top, ovr_m, exp_pulse;

  task automatic check(input string tag, input int obs, input int exp);
    cmp_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    line_m = 0; win_m = 0; armed_bot = 0; armed_top = 0;
    ovr_m = 0; exp_pulse = 0;
  endtask

  task automatic model_hs();
    if (line_m != LMAX) line_m++;
    if (win_m) begin
      if (line_m >= win_start + PL) win_m = 0;
    end else if (armed_bot && Enable && line_m == PS) begin
      win_m = 1; win_start = line_m; armed_bot = 0; armed_top = 0;
    end
`ifdef VCLK_TOP_PAD_EN
    else if (armed_top && Enable && line_m == TS) begin
      win_m = 1; win_start = line_m; armed_top = 0;
    end
`endif
    exp_pulse = win_m;
  endtask

  task automatic model_fs();
    if (win_m) ovr_m = 1;
    win_m = 0; line_m = 0; armed_bot = 1; armed_top = 1; exp_pulse = 0;
  endtask

  task automatic look(input string tag);
    check({tag, ".line"}, int'(LineCount), line_m);
    check({tag, ".line24"}, int'(Line24), int'(win_m));
    check({tag, ".padact"}, int'(PadActive), int'(win_m));
    check({tag, ".ovr"}, int'(Overrun), int'(ovr_m));
    check({tag, ".pulses"}, pulse_cnt - prev_pulses, int'(exp_pulse));
    prev_pulses = pulse_cnt;
  endtask

  task automatic do_hs(input string tag);
    nHSync = 1'b0; clks(4);
    nHSync = 1'b1; clks(4);
    model_hs();
    look(tag);
  endtask

  task automatic do_fs(input string tag);
    nFSync = 1'b0; clks(4);
    nFSync = 1'b1; clks(4);
    model_fs();
    look(tag);
  endtask

  task automatic do_both(input string tag);
    nFSync = 1'b0; nHSync = 1'b0; clks(4);
    nFSync = 1'b1; nHSync = 1'b1; clks(4);
    model_fs();
    look(tag);
  endtask

  initial begin
    model_reset();
    clks(3);
    check("rst.line24", int'(Line24), 0);
    check("rst.pulse", int'(VClkPulse), 0);
    check("rst.padact", int'(PadActive), 0);
    check("rst.line", int'(LineCount), 0);
    check("rst.ovr", int'(Overrun), 0);
    Reset = 1'b0;
    clks(2);
    prev_pulses = pulse_cnt;

    // Full enabled field.
    Enable = 1'b1;
    do_fs("f1.fs");
    base = pulse_cnt;
    repeat (230) do_hs("f1.hs");
    check("f1.total", pulse_cnt - base, NWIN);

    // Pass-through field.
    Enable = 1'b0;
    do_fs("f2.fs");
    base = pulse_cnt;
    repeat (230) do_hs("f2.hs");
    check("f2.total", pulse_cnt - base, 0);
    check("f2.line230", int'(LineCount), 230);

    // Field sync during the window, after the 10th padded line.
    Enable = 1'b1;
    do_fs("f3.fs");
    repeat (PS + 9) do_hs("f3.hs");
    do_fs("f3.ovr");
    check("f3.ovr_set", int'(Overrun), 1);
    base = pulse_cnt;
    repeat (230) do_hs("f4.hs");
    check("f4.total", pulse_cnt - base, NWIN);

    // Simultaneous sync edges: field sync wins.
    do_both("both");
    check("both.line0", int'(LineCount), 0);

    // Reset while a pad strobe is high at line 200.
    do_fs("f5.fs");
    repeat (199) do_hs("f5.hs");
    nHSync = 1'b0;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
        @(negedge Clk);
        if (VClkPulse === 1'b1) seen = 1;
      end
      check("rst.pulse_seen", int'(seen), 1);
    end
    model_hs();
    #1 Reset = 1'b1;
    #1;
    check("mid.line24", int'(Line24), 0);
    check("mid.pulse", int'(VClkPulse), 0);
    check("mid.padact", int'(PadActive), 0);
    check("mid.line", int'(LineCount), 0);
    check("mid.ovr", int'(Overrun), 0);
    nHSync = 1'b1;
    clks(2);
    Reset = 1'b0;
    clks(2);
    model_reset();
    prev_pulses = pulse_cnt;
    base = pulse_cnt;
    repeat (230) do_hs("f6.hs");
    check("f6.total", pulse_cnt - base, 0);

    // Long field: count saturates, no extra window.
    do_fs("f7.fs");
    repeat (LMAX + 4) do_hs("f7.hs");
    check("f7.sat", int'(LineCount), LMAX);

    // Random fields with Enable toggles and stray field syncs.
    for (int f = 0; f < 8; f++) begin
      int n;
      Enable = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) do_both("rnd.both");
      else do_fs("rnd.fs");
      n = $urandom_range(150, 260);
      for (int l = 0; l < n; l++) begin
        if ($urandom_range(0, 99) < 4) Enable = ~Enable;
        if ($urandom_range(0, 99) < 2) do_fs("rnd.midfs");
        else do_hs("rnd.hs");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule
